priority_arbiter_8: RTL and testbench
=====================================

PRIORITY_ARBITER_8 -- requirements
Module: priority_arbiter_8

Interface
REQ-001 Parameter MAX_HOLD, default 16: maximum consecutive cycles one requester may hold a grant; legal range 2..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  8  request lines; bit i = requester i.
REQ-005 rr_mode  input  1  0 = fixed priority (bit 7 highest); 1 = round-robin.
REQ-006 gnt  output  8  registered one-hot grant; all-zero when no grant.
REQ-007 gnt_id  output  3  binary index of granted requester; holds last winner when gnt_valid = 0.
REQ-008 gnt_valid  output  1  high exactly when gnt is non-zero.

Function
REQ-009 Three states: IDLE (no grant), GRANT (one requester owns resource), GAP (one dead cycle after any release or preemption).
REQ-010 IDLE: on an edge where req != 0, SHALL register winner into gnt/gnt_id, set gnt_valid, clear hold counter, go to GRANT; else stay IDLE.
REQ-011 Grant latency: gnt visible in the cycle directly after the edge sampling the request (1 cycle).
REQ-012 Fixed mode winner: highest set index of req (bit 7 beats bit 0).
REQ-013 Round-robin winner: first set bit searching downward from (last_id - 1) mod 8, wrapping 0 -> 7; last_id = most recent winner.
REQ-014 rr_mode sampled only on arbitration edges; changing it during GRANT has no effect on current holder.
REQ-015 GRANT: hold counter increments each cycle granted; counter width 8 bits, saturating not required since bounded by MAX_HOLD.
REQ-016 GRANT -> GAP when req[gnt_id] sampled low (release) or counter == MAX_HOLD-1 with req[gnt_id] still high (preemption); gnt cleared on that edge.
REQ-017 Release and preemption on the same edge: treated as release; identical outcome.
REQ-018 GAP lasts exactly one cycle, gnt = 0; at its end arbitrate over req sampled on that edge: any set -> GRANT, none -> IDLE.
REQ-019 A preempted requester still asserting may be re-granted after GAP if it wins arbitration (fixed mode: always, if still highest).
REQ-020 Requests from non-holders during GRANT are ignored until next arbitration edge; no queuing.
REQ-021 gnt SHALL never have more than one bit set; gnt_valid == |gnt at all times.

Reset
REQ-022 rst_n low: immediately state = IDLE, gnt = 0, gnt_id = 0, gnt_valid = 0, hold counter = 0, last_id = 0.
REQ-023 last_id = 0 makes first round-robin search start at bit 7, identical to fixed priority.
REQ-024 Reset asserted mid-grant drops the grant asynchronously; first arbitration after deassertion uses REQ-010.

Structure
REQ-025 Shared package arb_pkg: N_REQ = 8, ID_W = 3, state encodings IDLE/GRANT/GAP.
REQ-026 One combinational sub-module rr_priority_pick (inputs req[7:0], start index, mode; outputs winner id, any) instantiated once.
REQ-027 All outputs driven directly from registers.

Verification
REQ-028 Reset then req = 8'b0010_0100, fixed -> after 1 edge gnt = 8'b0010_0000, gnt_id = 5, gnt_valid = 1.
REQ-029 Holder 5 drops req while req[2] high -> next cycle gnt = 0 (GAP), following cycle gnt = 8'b0000_0100.
REQ-030 MAX_HOLD = 4, req[7] held high continuously, fixed -> gnt[7] high 4 cycles, 1 GAP cycle, re-granted; repeats.
REQ-031 rr_mode = 1, req = 8'hFF held, MAX_HOLD = 2 -> grant sequence 7,6,5,...,0,7, each 2 cycles separated by 1 GAP cycle.
REQ-032 rst_n pulsed low mid-grant -> gnt = 0 same cycle without clock; after release, req = 8'h01 -> gnt_id = 0 one edge later.
REQ-033 Random req/rr_mode for 10k cycles -> assertions: gnt one-hot-or-zero, gnt_valid == |gnt, no holder exceeds MAX_HOLD cycles, no grant to a requester whose req was low on the granting edge.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants, state encoding and helpers for the 8-way priority arbiter.
package arb_pkg;

    localparam int unsigned N_REQ  = 8;
    localparam int unsigned ID_W   = 3;
    localparam int unsigned HOLD_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    // Binary requester index to one-hot grant vector.
    function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        return N_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational winner search: scans downward from a start index with wrap,
// or from the top index when fixed priority is selected.
module rr_priority_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  start_i,
    input  logic             rr_mode_i,
    output logic [ID_W-1:0]  win_id_o,
    output logic             any_o
);

    logic [ID_W-1:0] base;
    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        base     = rr_mode_i ? start_i : ID_W'(N_REQ - 1);
        idx      = '0;
        found    = 1'b0;
        win_id_o = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = base - ID_W'(k);
            if (!found && req_i[idx]) begin
                win_id_o = idx;
                found    = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/priority_arbiter_8.sv
// 8-requester arbiter with fixed or round-robin priority, a bounded hold time
// per grant and one dead cycle after every release or preemption.
module priority_arbiter_8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             rr_mode,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_e         state_q,     state_d;
    logic [N_REQ-1:0]   gnt_q,       gnt_d;
    logic [ID_W-1:0]    gnt_id_q,    gnt_id_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [HOLD_W-1:0]  hold_q,      hold_d;

    logic [ID_W-1:0]    rr_start;
    logic [ID_W-1:0]    pick_id;
    logic               pick_any;
    logic               holder_req;
    logic               hold_expired;

    // gnt_id_q also serves as the last winner for the round-robin pointer.
    assign rr_start     = gnt_id_q - ID_W'(1);
    assign holder_req   = req[gnt_id_q];
    assign hold_expired = (hold_q == HOLD_LAST);

    rr_priority_pick u_pick (
        .req_i     (req),
        .start_i   (rr_start),
        .rr_mode_i (rr_mode),
        .win_id_o  (pick_id),
        .any_o     (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        hold_d      = hold_q;

        unique case (state_q)
            IDLE, GAP: begin
                if (pick_any) begin
                    state_d     = GRANT;
                    gnt_d       = id_to_onehot(pick_id);
                    gnt_id_d    = pick_id;
                    gnt_valid_d = 1'b1;
                    hold_d      = '0;
                end else begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                end
            end
            GRANT: begin
                // Release and preemption share one exit path, so coincidence needs no tie-break.
                if (!holder_req || hold_expired) begin
                    state_d     = GAP;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    hold_d      = '0;
                end else begin
                    hold_d      = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                hold_d      = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            hold_q      <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_priority_arbiter_8.sv
// Self-checking bench for priority_arbiter_8: directed scenarios plus a long
// random run compared against an ownership-level reference model.
module tb_priority_arbiter_8;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       rr_mode;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;

    int n_checks;
    int n_fail;

    // Reference model: who owns the resource, for how many cycles, last winner.
    int m_holder;
    int m_held;
    int m_last;

    // Observed run length of the current DUT grant.
    int         run_len;
    logic [7:0] prev_gnt;

    priority_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .rr_mode   (rr_mode),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input logic m, input int last);
        int idx;
        if (!m) begin
            for (int i = 7; i >= 0; i--)
                if (r[i]) return i;
        end else begin
            for (int k = 1; k <= 8; k++) begin
                idx = (last - k + 16) % 8;
                if (r[idx]) return idx;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_holder = -1;
        m_held   = 0;
        m_last   = 0;
        run_len  = 0;
        prev_gnt = '0;
    endtask

    task automatic model_edge(input logic [7:0] r, input logic m);
        if (m_holder >= 0) begin
            m_held++;
            if (!r[m_holder] || m_held >= MAX_HOLD) m_holder = -1;
        end else if (r != 8'h00) begin
            m_holder = pick(r, m, m_last);
            m_last   = m_holder;
            m_held   = 0;
        end
    endtask

    task automatic compare_model();
        logic [7:0] e_gnt;
        e_gnt = '0;
        if (m_holder >= 0) e_gnt[m_holder] = 1'b1;
        check("model_gnt",   gnt,       e_gnt);
        check("model_id",    gnt_id,    m_last[2:0]);
        check("model_valid", gnt_valid, (m_holder >= 0) ? 1 : 0);
        check("onehot0",     $onehot0(gnt) ? 1 : 0, 1);
        check("valid_or",    gnt_valid, |gnt);
        if (gnt != 8'h00 && gnt == prev_gnt) run_len++;
        else run_len = (gnt != 8'h00) ? 1 : 0;
        prev_gnt = gnt;
        check("hold_len_ok", (run_len <= MAX_HOLD) ? 1 : 0, 1);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic [7:0] r, input logic m);
        req     = r;
        rr_mode = m;
        @(posedge clk);
        model_edge(r, m);
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [7:0] cur_req;
        logic       cur_mode;
        int         slot;
        int         pos;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        req      = '0;
        rr_mode  = 1'b0;
        model_reset();

        repeat (2) @(negedge clk);
        check("reset_gnt",   gnt,       8'h00);
        check("reset_id",    gnt_id,    3'd0);
        check("reset_valid", gnt_valid, 1'b0);
        rst_n = 1'b1;

        // Fixed priority first grant, then release with a lower requester waiting.
        step(8'b0010_0100, 1'b0);
        check("first_gnt",   gnt,       8'b0010_0000);
        check("first_id",    gnt_id,    3'd5);
        check("first_valid", gnt_valid, 1'b1);
        step(8'b0000_0100, 1'b0);
        check("release_gap", gnt, 8'h00);
        step(8'b0000_0100, 1'b0);
        check("after_gap_gnt", gnt,    8'b0000_0100);
        check("after_gap_id",  gnt_id, 3'd2);
        repeat (3) step(8'h00, 1'b0);

        // Continuous request is preempted every MAX_HOLD cycles and re-granted.
        for (int k = 1; k <= 15; k++) begin
            step(8'h80, 1'b0);
            check("preempt_cycle", gnt, (k % 5 == 0) ? 8'h00 : 8'h80);
        end

        // Round-robin from reset walks 7 down to 0 and wraps.
        do_reset();
        for (int k = 1; k <= 45; k++) begin
            step(8'hFF, 1'b1);
            slot = (k - 1) / 5;
            pos  = (k - 1) % 5;
            check("rr_walk", gnt, (pos == 4) ? 8'h00 : (8'h80 >> (slot % 8)));
        end

        // Asynchronous reset drops the grant without a clock edge.
        step(8'hFF, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_gnt",   gnt,       8'h00);
        check("async_rst_valid", gnt_valid, 1'b0);
        check("async_rst_id",    gnt_id,    3'd0);
        req = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(8'h01, 1'b0);
        check("post_rst_id",  gnt_id, 3'd0);
        check("post_rst_gnt", gnt,    8'h01);
        step(8'h00, 1'b0);

        // Random traffic: sticky requests so holds and preemptions occur.
        cur_req  = 8'h00;
        cur_mode = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(3) == 0)
                cur_req = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(15) == 0) cur_mode = ~cur_mode;
            step(cur_req, cur_mode);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
